// File: rtl/pixel_streamer_pkg.sv
// rtl/pixel_streamer_pkg.sv - shared defaults, state encoding and width helpers for the pixel streamer
package pixel_streamer_pkg;

    localparam int PS_DATA_WIDTH = 8;
    localparam int PS_IMG_W      = 32;
    localparam int PS_IMG_H      = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREFETCH,
        ST_STREAM,
        ST_FINISH
    } state_t;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int raster_addr_width(input int w, input int h);
        return cnt_width(w * h);
    endfunction

endpackage

// File: rtl/pixel_frame_ram.sv
// rtl/pixel_frame_ram.sv - frame store: one write port, one registered read port with 1-cycle latency
module pixel_frame_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // No reset: frame contents must survive a streamer reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/pixel_streamer.sv
// rtl/pixel_streamer.sv - streams a stored frame in raster order with sof/eol/eof and ready backpressure
module pixel_streamer
    import pixel_streamer_pkg::*;
#(
    parameter int DATA_WIDTH = PS_DATA_WIDTH,
    parameter int IMG_W      = PS_IMG_W,
    parameter int IMG_H      = PS_IMG_H,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  start,
    input  logic                  ready_in,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] pixel_out,
    output logic                  sof,
    output logic                  eol,
    output logic                  eof,
    output logic                  busy,
    output logic                  done
);

    localparam int          XW     = cnt_width(IMG_W);
    localparam int          YW     = cnt_width(IMG_H);
    localparam int unsigned NPIX   = IMG_W * IMG_H;
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    state_t                state_q, state_d;
    logic [XW-1:0]         rx_q, rx_d, px_q, px_d;
    logic [YW-1:0]         ry_q, ry_d, py_q, py_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic                  rd_done_q, rd_done_d, pend_q, pend_d;
    logic                  valid_q, valid_d, sof_q, sof_d, eol_q, eol_d, eof_q, eof_d;
    logic [DATA_WIDTH-1:0] pix_q, pix_d, ram_rdata;
    logic                  ram_we, rd_en, move, xfer;

    assign ram_we = wr_en && (state_q == ST_IDLE) && (32'(wr_addr) < NPIX);

    pixel_frame_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk    (clk),
        .wr_en  (ram_we),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .rd_en  (rd_en),
        .rd_addr(raddr_q),
        .rd_data(ram_rdata)
    );

    // The RAM output register acts as the skid stage (pend_q); it only reloads once drained.
    always_comb begin
        state_d   = state_q;
        rx_d      = rx_q;
        ry_d      = ry_q;
        px_d      = px_q;
        py_d      = py_q;
        raddr_d   = raddr_q;
        rd_done_d = rd_done_q;
        pend_d    = pend_q;
        valid_d   = valid_q;
        pix_d     = pix_q;
        sof_d     = sof_q;
        eol_d     = eol_q;
        eof_d     = eof_q;
        xfer      = valid_q && ready_in;
        move      = pend_q && (!valid_q || ready_in);
        rd_en     = ((state_q == ST_PREFETCH) || (state_q == ST_STREAM)) &&
                    !rd_done_q && (!pend_q || move);

        if (rd_en) begin
            px_d    = rx_q;
            py_d    = ry_q;
            raddr_d = raddr_q + ADDR_WIDTH'(1);
            if (rx_q == X_LAST) begin
                rx_d = '0;
                if (ry_q == Y_LAST) rd_done_d = 1'b1;
                else                ry_d      = ry_q + YW'(1);
            end else begin
                rx_d = rx_q + XW'(1);
            end
        end

        if (rd_en)     pend_d = 1'b1;
        else if (move) pend_d = 1'b0;

        if (move) begin
            valid_d = 1'b1;
            pix_d   = ram_rdata;
            sof_d   = (px_q == '0) && (py_q == '0);
            eol_d   = (px_q == X_LAST);
            eof_d   = (px_q == X_LAST) && (py_q == Y_LAST);
        end else if (xfer) begin
            valid_d = 1'b0;
            sof_d   = 1'b0;
            eol_d   = 1'b0;
            eof_d   = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_PREFETCH;
                    rx_d      = '0;
                    ry_d      = '0;
                    raddr_d   = '0;
                    rd_done_d = 1'b0;
                end
            end
            ST_PREFETCH: state_d = ST_STREAM;
            ST_STREAM:   if (xfer && eof_q) state_d = ST_FINISH;
            ST_FINISH:   state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rx_q      <= '0;
            ry_q      <= '0;
            px_q      <= '0;
            py_q      <= '0;
            raddr_q   <= '0;
            rd_done_q <= 1'b0;
            pend_q    <= 1'b0;
            valid_q   <= 1'b0;
            pix_q     <= '0;
            sof_q     <= 1'b0;
            eol_q     <= 1'b0;
            eof_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_q      <= rx_d;
            ry_q      <= ry_d;
            px_q      <= px_d;
            py_q      <= py_d;
            raddr_q   <= raddr_d;
            rd_done_q <= rd_done_d;
            pend_q    <= pend_d;
            valid_q   <= valid_d;
            pix_q     <= pix_d;
            sof_q     <= sof_d;
            eol_q     <= eol_d;
            eof_q     <= eof_d;
        end
    end

    assign valid_out = valid_q;
    assign pixel_out = pix_q;
    assign sof       = sof_q;
    assign eol       = eol_q;
    assign eof       = eof_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_FINISH);

endmodule

// File: tb/tb_pixel_streamer.sv
// tb/tb_pixel_streamer.sv - scoreboard bench for pixel_streamer on a 4x4 frame
module tb_pixel_streamer;

    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int AW = 5;
    localparam int NP = W * H;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic          start = 1'b0;
    logic          ready_in = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          valid_out, sof, eol, eof, busy, done;
    logic [DW-1:0] pixel_out;

    pixel_streamer #(
        .DATA_WIDTH(DW),
        .IMG_W     (W),
        .IMG_H     (H),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .start    (start),
        .ready_in (ready_in),
        .valid_out(valid_out),
        .pixel_out(pixel_out),
        .sof      (sof),
        .eol      (eol),
        .eof      (eof),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;
    int frames_done = 0;
    int xfer_cnt = 0;
    int rdy_mode = 0;
    int rdy_phase = 0;

    logic [DW-1:0] model [NP];
    logic [DW+2:0] sb [$];
    logic [DW+2:0] held, e;
    logic          stall_prev = 1'b0;
    logic          eof_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // 0: always ready, 1: repeating 1,0,0,1, other: random
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: ready_in = 1'b1;
            1: begin
                ready_in  = (rdy_phase == 0) || (rdy_phase == 3);
                rdy_phase = (rdy_phase + 1) % 4;
            end
            default: ready_in = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
            eof_prev   = 1'b0;
        end else begin
            if (stall_prev)
                check("stall_hold", 32'({valid_out, eof, eol, sof, pixel_out}), 32'({1'b1, held}));
            if (eof_prev || done)
                check("done_pulse", 32'(done), 32'(eof_prev));
            if (done) frames_done++;
            stall_prev = 1'b0;
            eof_prev   = 1'b0;
            if (valid_out && ready_in) begin
                xfer_cnt++;
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_pixel: got 0x%0h expected none", pixel_out);
                end else begin
                    e = sb.pop_front();
                    check("pixel_flags", 32'({eof, eol, sof, pixel_out}), 32'(e));
                end
                eof_prev = eof;
            end else if (valid_out) begin
                stall_prev = 1'b1;
                held       = {eof, eol, sof, pixel_out};
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame();
        for (int a = 0; a < NP; a++)
            sb.push_back({(a == NP - 1), (a % W == W - 1), (a == 0), model[a]});
    endtask

    task automatic wr(input int a, input int d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = DW'(d);
        if (a < NP) model[a] = DW'(d);
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic start_frame(input bit do_wr, input int wa, input int wd);
        if (do_wr) begin
            wr_en     = 1'b1;
            wr_addr   = AW'(wa);
            wr_data   = DW'(wd);
            model[wa] = DW'(wd);
        end
        push_frame();
        xfer_cnt = 0;
        start    = 1'b1;
        cyc();
        start = 1'b0;
        wr_en = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        check("valid_edge1", 32'(valid_out), 32'd0);
        cyc();
        check("valid_edge2", 32'(valid_out), 32'd0);
        cyc();
        check("valid_latency", 32'(valid_out), 32'd1);
        check("first_pixel", 32'(pixel_out), 32'(model[0]));
        check("first_sof", 32'(sof), 32'd1);
    endtask

    task automatic wait_done(output int cycles);
        int f0;
        f0     = frames_done;
        cycles = 0;
        while (frames_done == f0 && cycles < 400) begin
            cyc();
            cycles++;
        end
        check("frame_done_seen", 32'(frames_done - f0), 32'd1);
        check("sb_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid"}, 32'(valid_out), 32'd0);
        check({tag, "_pixel"}, 32'(pixel_out), 32'd0);
        check({tag, "_flags"}, 32'({sof, eol, eof}), 32'd0);
        check({tag, "_busy_done"}, 32'({busy, done}), 32'd0);
    endtask

    initial begin
        int c;
        #2;
        check_outputs_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc();

        // ramp frame, full-rate streaming
        for (int a = 0; a < NP; a++) wr(a, a);
        wr(NP + 3, 8'h55);
        rdy_mode = 0;
        start_frame(1'b0, 0, 0);
        wait_done(c);
        check("no_bubble_cycles", 32'(c), 32'd17);

        // ready pattern 1,0,0,1
        rdy_mode  = 1;
        rdy_phase = 0;
        start_frame(1'b0, 0, 0);
        wait_done(c);

        // start and write while busy are ignored
        rdy_mode = 2;
        start_frame(1'b0, 0, 0);
        repeat (3) cyc();
        start   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = AW'(5);
        wr_data = 8'hAA;
        cyc();
        start = 1'b0;
        wr_en = 1'b0;
        wait_done(c);
        repeat (10) cyc();
        check("idle_after_busy_start", 32'({busy, valid_out}), 32'd0);

        // write and start in the same cycle; address 5 must keep its loaded value
        rdy_mode = 0;
        start_frame(1'b1, 0, 8'h7F);
        wait_done(c);

        // reset after pixel 6 transfers
        rdy_mode = 1;
        start_frame(1'b0, 0, 0);
        c = 0;
        while (xfer_cnt < 7 && c < 200) begin
            cyc();
            c++;
        end
        check("reached_pixel6", 32'(xfer_cnt >= 7), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midframe_reset");
        sb.delete();
        cyc();
        cyc();
        rst_n = 1'b1;
        repeat (3) cyc();
        check("idle_after_reset", 32'({busy, valid_out}), 32'd0);
        rdy_mode = 0;
        start_frame(1'b0, 0, 0);
        wait_done(c);

        // random frames with random backpressure
        for (int f = 0; f < 3; f++) begin
            for (int a = 0; a < NP; a++) wr(a, int'($urandom_range(0, 255)));
            wr(int'($urandom_range(NP, 2**AW - 1)), int'($urandom_range(0, 255)));
            rdy_mode = 2;
            start_frame(1'b0, 0, 0);
            wait_done(c);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
